// File: rtl/pf_lanectrl_pkg.sv
// Shared types and helpers for the multi-lane HS_IO_CLK_PAUSE synchroniser.
// Holds the stretcher state encoding and the parameter-legality check.
package pf_lanectrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } st_e;

  localparam int TMR_W = 4;

  function automatic bit params_ok(
    input int nl,
    input int ss,
    input int mp,
    input int mg,
    input int fe,
    input int cw
  );
    return (nl >= 1) && (nl <= 16)
        && (ss >= 0) && (ss <= 4)
        && (mp >= 1) && (mp <= 15)
        && (mg >= 0) && (mg <= 15)
        && ((fe == 0) || (fe == 1))
        && (cw >= 1);
  endfunction

endpackage

// File: rtl/pf_lanectrl_pause_sync_mlane_if.sv
// Pause bundle: requests, lane enables and counter clear in (slave side);
// conditioned pauses, PAUSE_ACTIVE and packed EVENT_CNT out.
interface pf_lanectrl_pause_sync_mlane_if #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 8
);

  logic [NUM_LANES-1:0]       HS_IO_CLK_PAUSE;
  logic [NUM_LANES-1:0]       LANE_EN;
  logic                       CNT_CLR;
  logic [NUM_LANES-1:0]       HS_IO_CLK_PAUSE_SYNC;
  logic                       PAUSE_ACTIVE;
  logic [NUM_LANES*CNT_W-1:0] EVENT_CNT;

  modport master (
    output HS_IO_CLK_PAUSE,
    output LANE_EN,
    output CNT_CLR,
    input  HS_IO_CLK_PAUSE_SYNC,
    input  PAUSE_ACTIVE,
    input  EVENT_CNT
  );

  modport slave (
    input  HS_IO_CLK_PAUSE,
    input  LANE_EN,
    input  CNT_CLR,
    output HS_IO_CLK_PAUSE_SYNC,
    output PAUSE_ACTIVE,
    output EVENT_CNT
  );

endinterface

// File: rtl/pf_lanectrl_pause_lane.sv
// One pause lane: sync chain, IDLE/HOLD/GAP stretcher, output flop, counter.
// Ports: CLK, RESET, pause_in, lane_en, cnt_clr -> pause_out, event_cnt.
module pf_lanectrl_pause_lane
  import pf_lanectrl_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_PAUSE_CYCLES = 2,
  parameter int MIN_GAP_CYCLES   = 1,
  parameter int FALL_EDGE_OUT    = 0,
  parameter int CNT_W            = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             pause_in,
  input  logic             lane_en,
  input  logic             cnt_clr,
  output logic             pause_out,
  output logic [CNT_W-1:0] event_cnt
);

  localparam logic [TMR_W-1:0] W_LD =
    TMR_W'(MIN_PAUSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] G_LD =
    TMR_W'((MIN_GAP_CYCLES > 0) ? MIN_GAP_CYCLES - 1 : 0);

  logic s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = pause_in;
  end else begin : g_sync
    (* syn_keep = 1 *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = pause_in;
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) sync_q <= '0;
      else       sync_q <= sync_d;
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  st_e              st_q, st_d;
  logic [TMR_W-1:0] wcnt_q, wcnt_d;
  logic [TMR_W-1:0] gcnt_q, gcnt_d;
  logic             pend_q, pend_d;
  logic             p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    st_d   = st_q;
    wcnt_d = wcnt_q;
    gcnt_d = gcnt_q;
    pend_d = pend_q;
    unique case (st_q)
      ST_IDLE: begin
        if (s) begin
          st_d   = ST_HOLD;
          wcnt_d = W_LD;
        end
      end
      ST_HOLD: begin
        if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
        if (!s && wcnt_q == '0) begin
          if (MIN_GAP_CYCLES > 0) begin
            st_d   = ST_GAP;
            gcnt_d = G_LD;
          end else begin
            st_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // requests seen while the gap runs are
        // remembered and served when it expires
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - 1'b1;
          pend_d = pend_q | s;
        end else if (s || pend_q) begin
          st_d   = ST_HOLD;
          wcnt_d = W_LD;
          pend_d = 1'b0;
        end else begin
          st_d   = ST_IDLE;
          pend_d = 1'b0;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (!lane_en) begin
      st_d   = ST_IDLE;
      pend_d = 1'b0;
    end
    p_d   = (st_d == ST_HOLD);
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (p_d && st_q != ST_HOLD
                 && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st_q   <= ST_IDLE;
      wcnt_q <= '0;
      gcnt_q <= '0;
      pend_q <= 1'b0;
      p_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      wcnt_q <= wcnt_d;
      gcnt_q <= gcnt_d;
      pend_q <= pend_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
    end
  end

  if (FALL_EDGE_OUT != 0) begin : g_neg
    logic out_q, out_d;
    assign out_d = p_q;

    always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) out_q <= 1'b0;
      else       out_q <= out_d;
    end

    assign pause_out = out_q;
  end else begin : g_pos
    assign pause_out = p_q;
  end

  assign event_cnt = cnt_q;

endmodule

// File: rtl/pf_lanectrl_pause_sync_mlane.sv
// NUM_LANES independent pause stretchers into the LANECTRL clock domain.
// Ports: CLK, RESET, bus (slave): per-lane pauses, PAUSE_ACTIVE, EVENT_CNT.
module pf_lanectrl_pause_sync_mlane
  import pf_lanectrl_pkg::*;
#(
  parameter int NUM_LANES        = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_PAUSE_CYCLES = 2,
  parameter int MIN_GAP_CYCLES   = 1,
  parameter int FALL_EDGE_OUT    = 0,
  parameter int CNT_W            = 8
) (
  input logic CLK,
  input logic RESET,
  pf_lanectrl_pause_sync_mlane_if.slave bus
);

  localparam bit PARAMS_OK = params_ok(
    NUM_LANES, SYNC_STAGES, MIN_PAUSE_CYCLES,
    MIN_GAP_CYCLES, FALL_EDGE_OUT, CNT_W);

  if (!PARAMS_OK) begin : g_bad_params
    $error("pf_lanectrl_pause_sync_mlane: bad params");
  end

  logic [NUM_LANES-1:0]       out_w;
  logic [NUM_LANES*CNT_W-1:0] cnt_w;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pf_lanectrl_pause_lane #(
      .SYNC_STAGES      (SYNC_STAGES),
      .MIN_PAUSE_CYCLES (MIN_PAUSE_CYCLES),
      .MIN_GAP_CYCLES   (MIN_GAP_CYCLES),
      .FALL_EDGE_OUT    (FALL_EDGE_OUT),
      .CNT_W            (CNT_W)
    ) u_lane (
      .CLK       (CLK),
      .RESET     (RESET),
      .pause_in  (bus.HS_IO_CLK_PAUSE[i]),
      .lane_en   (bus.LANE_EN[i]),
      .cnt_clr   (bus.CNT_CLR),
      .pause_out (out_w[i]),
      .event_cnt (cnt_w[i*CNT_W +: CNT_W])
    );
  end

  assign bus.HS_IO_CLK_PAUSE_SYNC = out_w;
  assign bus.PAUSE_ACTIVE         = |out_w;
  assign bus.EVENT_CNT            = cnt_w;

endmodule

// File: doc/pf_lanectrl_pause_sync_mlane.md
Name: pf_lanectrl_pause_sync_mlane

Overview:
Multi-lane successor to the single-lane HS_IO_CLK_PAUSE synchroniser. It synchronises NUM_LANES independent pause requests into the lane-controller clock domain. Each pause is stretched to a programmable minimum width and followed by a programmable minimum gap. The output can optionally be retimed to the falling edge. It sits between the IOD training/alignment controller and the per-lane LANECTRL HS_IO_CLK_PAUSE pins, and counts pause events per lane for SmartDebug visibility.

Parameters:
NUM_LANES, 4, number of independent pause lanes (1..16)
SYNC_STAGES, 2, synchroniser flops per lane before the stretcher (0..4); 0 = input sampled directly by the FSM
MIN_PAUSE_CYCLES, 2, minimum asserted width of each output pause in CLK cycles (1..15)
MIN_GAP_CYCLES, 1, minimum deasserted cycles between consecutive output pauses (0..15)
FALL_EDGE_OUT, 0, 1 = final output flop clocked on negedge CLK
CNT_W, 8, width of each per-lane saturating event counter

Ports:
CLK  in  1  lane-controller clock
RESET  in  1  asynchronous, active-high reset
HS_IO_CLK_PAUSE  in  NUM_LANES  per-lane pause request, asynchronous to CLK
LANE_EN  in  NUM_LANES  per-lane enable, synchronous to CLK
CNT_CLR  in  1  synchronous clear of all event counters
HS_IO_CLK_PAUSE_SYNC  out  NUM_LANES  per-lane conditioned pause to LANECTRL
PAUSE_ACTIVE  out  1  OR of all lanes' HS_IO_CLK_PAUSE_SYNC (registered as the per-lane outputs, no extra latency)
EVENT_CNT  out  NUM_LANES*CNT_W  per-lane pause-event counts; lane i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset: RESET is asynchronous, active-high; clock is CLK. Every flop clears asynchronously, including the negedge output flop: sync chains 0, FSM IDLE, counters 0, all outputs 0. Outputs drop to 0 immediately on RESET assertion, including mid-pause.
- Per lane, a sync chain of SYNC_STAGES posedge flops feeds signal s to the stretcher FSM. Sync flops carry syn_keep.
- FSM states are IDLE, HOLD, GAP. Output p is registered; p=1 only in HOLD.
  - IDLE: s=1 -> HOLD; load width counter.
  - HOLD: leave only when s=0 AND at least MIN_PAUSE_CYCLES cycles have been spent in HOLD. Go to GAP with the gap counter loaded if MIN_GAP_CYCLES>0, else go to IDLE.
  - GAP: p=0 regardless of s. When the gap counter expires: s=1 -> HOLD directly; s=0 -> IDLE. A request arriving during GAP is deferred, not lost.
- Output high width = max(L, MIN_PAUSE_CYCLES), where L = synchronised input high length in cycles. Output low between pauses >= MIN_GAP_CYCLES.
- Latency, input rise to output rise: SYNC_STAGES+1 posedges. FALL_EDGE_OUT=1 adds half a cycle; the negedge flop captures p.
- LANE_EN=0: FSM forced to IDLE and p=0 on the next posedge, including mid-HOLD or mid-GAP. The sync chain keeps running. Re-enabling with s=1 enters HOLD on the following posedge.
- Counters:
  - EVENT_CNT[i] increments by 1 on each transition into HOLD (from IDLE or GAP).
  - Saturates at 2^CNT_W-1; no wrap.
  - CNT_CLR=1 clears all lanes; clear wins over a simultaneous increment.
  - Counter is unaffected by LANE_EN.
- Lanes are fully independent; no cross-lane arbitration.

Decomposition:
- Shared package/header pf_lanectrl_pkg holds:
  - FSM state encodings: ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2.
  - A parameter-legality check constant, with elaboration error on out-of-range values.
- One natural sub-module, pf_lanectrl_pause_lane: sync chain, FSM, width/gap counters, output flop and event counter for a single lane. The top generates NUM_LANES instances, ORs their outputs into PAUSE_ACTIVE, and packs EVENT_CNT.

Test Plan:
- Defaults, lane0 input high 1 cycle -> output rises 3 posedges later, stays high exactly 2 cycles; EVENT_CNT[0]=1, other lanes 0.
- MIN_PAUSE_CYCLES=3, input high 5 cycles -> output high 5 cycles; input high 1 cycle -> output high 3 cycles.
- MIN_GAP_CYCLES=4, two 1-cycle pulses 3 cycles apart -> second output pause starts exactly 4 low cycles after the first ends; count=2.
- LANE_EN[1] deasserted during the 2nd cycle of a 6-cycle pause -> output 0 next posedge. Re-enable with input still high -> re-enters HOLD, count increments to 2.
- CNT_W=2, 5 pauses on lane 2 -> EVENT_CNT lane 2 = 3 (saturated). CNT_CLR coincident with a new pause -> 0.
- FALL_EDGE_OUT=1, RESET asserted mid-pause -> output 0 asynchronously. After release, a pause appears at SYNC_STAGES+1.5 cycles.
